// File: rtl/clk_div_monitor.sv
// Receive-side checker for a divided clock: measures period and sampled high
// time in source-clock cycles and flags period, duty and stuck-clock errors.
module clk_div_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = 5,
  parameter int unsigned HIGH_MIN   = 2,
  parameter int unsigned HIGH_MAX   = 3,
  parameter int unsigned TIMEOUT    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             period_ok,
  output logic             duty_ok,
  output logic             stuck,
  output logic [7:0]       err_cnt
);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_EXP  = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] LP_HMIN = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] LP_HMAX = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] LP_TO   = CNT_W'(TIMEOUT);

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_sd;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;

  logic w_rise;
  logic w_per_good;
  logic w_duty_good;
  logic w_timeout;
  logic w_err_sat;

  assign w_rise      = r_s2 & ~r_sd;
  assign w_per_good  = (r_per_cnt == LP_EXP);
  assign w_duty_good = (r_hi_cnt >= LP_HMIN) && (r_hi_cnt <= LP_HMAX);
  assign w_timeout   = (r_per_cnt == LP_TO);
  assign w_err_sat   = &err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_sd       <= 1'b0;
      r_per_cnt  <= '0;
      r_hi_cnt   <= '0;
      period     <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      period_ok  <= 1'b0;
      duty_ok    <= 1'b0;
      stuck      <= 1'b0;
      err_cnt    <= '0;
    end else begin
      // Synchronizer runs regardless of en so a rise can arm as en returns.
      r_s1       <= sig_in;
      r_s2       <= r_s1;
      r_sd       <= r_s2;
      meas_valid <= 1'b0;
      if (!en) begin
        r_state   <= IDLE;
        r_per_cnt <= '0;
        r_hi_cnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise) begin
              r_state   <= MEAS;
              r_per_cnt <= LP_ONE;
              r_hi_cnt  <= LP_ONE;
            end
          end
          MEAS: begin
            // A rise on the timeout cycle still completes the measurement.
            if (w_rise) begin
              period     <= r_per_cnt;
              high_cnt   <= r_hi_cnt;
              meas_valid <= 1'b1;
              period_ok  <= w_per_good;
              duty_ok    <= w_duty_good;
              stuck      <= 1'b0;
              if ((!w_per_good || !w_duty_good) && !w_err_sat) begin
                err_cnt <= err_cnt + 8'd1;
              end
              r_per_cnt <= LP_ONE;
              r_hi_cnt  <= LP_ONE;
            end else if (w_timeout) begin
              stuck     <= 1'b1;
              if (!w_err_sat) begin
                err_cnt <= err_cnt + 8'd1;
              end
              r_state   <= IDLE;
              r_per_cnt <= '0;
              r_hi_cnt  <= '0;
            end else begin
              if (!(&r_per_cnt)) begin
                r_per_cnt <= r_per_cnt + LP_ONE;
              end
              if (r_s2 && !(&r_hi_cnt)) begin
                r_hi_cnt <= r_hi_cnt + LP_ONE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Receive-side checker for the divided clocks our divider blocks generate, e.g. the 50%-duty divide-by-5 output.
- Samples a divided clock `sig_in` in the source clock domain, measures its period and high time in source-clock cycles, and flags period, duty and stuck-clock errors.
- Sits beside each divider instance as an on-chip self-check; its results feed the status/debug registers.

Parameters:
- CNT_W, 8, width of period/high counters and outputs.
- EXP_PERIOD, 5, required period in clk cycles.
- HIGH_MIN, 2, minimum acceptable sampled high count.
- HIGH_MAX, 3, maximum acceptable sampled high count.
- TIMEOUT, 32, cycles without a rising edge before stuck is declared; must be < 2^CNT_W.

Ports:
- clk  input  1  source clock; everything is on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  monitor enable; low forces IDLE.
- sig_in  input  1  divided clock under test, treated as asynchronous.
- period  output  CNT_W  last measured period in clk cycles.
- high_cnt  output  CNT_W  last measured sampled high count.
- meas_valid  output  1  one-cycle pulse when period/high_cnt update.
- period_ok  output  1  last period == EXP_PERIOD.
- duty_ok  output  1  HIGH_MIN <= last high_cnt <= HIGH_MAX.
- stuck  output  1  no rising edge within TIMEOUT cycles.
- err_cnt  output  8  saturating count of failed measurements.

Behaviour:
- Reset (async, rst=1): all outputs 0, internal counters 0, synchronizer flops 0, state IDLE.
- Input capture chain:
  - s1 <= sig_in; s2 <= s1; sd <= s2.
  - rise = s2 & ~sd (combinational).
  - A sig_in edge is detected on the 3rd clk posedge after it is sampled; this fixed latency is not visible in measured values.
- States: IDLE, MEAS.
- IDLE:
  - per_cnt/hi_cnt hold 0.
  - On rise with en=1: go to MEAS, per_cnt <= 1, hi_cnt <= 1.
  - No meas_valid is produced in IDLE.
- MEAS, cycle without rise:
  - per_cnt <= per_cnt+1, saturating at 2^CNT_W-1.
  - hi_cnt <= hi_cnt+s2, saturating.
- MEAS, cycle with rise:
  - period <= per_cnt; high_cnt <= hi_cnt; meas_valid <= 1 for exactly one cycle.
  - period_ok <= (per_cnt==EXP_PERIOD); duty_ok <= hi_cnt within [HIGH_MIN, HIGH_MAX].
  - If either check fails, err_cnt <= err_cnt+1, saturating at 255.
  - stuck <= 0.
  - per_cnt <= 1, hi_cnt <= 1; remain in MEAS.
  - Measurements run back-to-back with no dead cycle.
- Timeout in MEAS:
  - Condition: per_cnt == TIMEOUT and no rise this cycle.
  - Action: stuck <= 1, err_cnt += 1 (saturating), go to IDLE, no meas_valid.
  - period, high_cnt, period_ok and duty_ok hold their last values.
- Simultaneous rise and timeout on the same cycle: rise wins, measurement completes normally.
- stuck is sticky: it clears only on the next completed measurement, i.e. the second rise after recovery.
- en=0, any state:
  - Next cycle the state is IDLE with per_cnt = hi_cnt = 0.
  - Any in-progress measurement is discarded with no meas_valid.
  - Outputs hold.
  - Synchronizer keeps running, so a rise seen in the same cycle en returns high can arm.
- Reset mid-measurement: immediate clear; the first measurement after reset needs two rises.
- Outputs are registered; meas_valid is asserted in the cycle after the rise cycle.

Test Plan:
- Divide-by-5 pattern (sig_in high 3 clk, low 2 clk, repeated 10 periods): first meas_valid after the 2nd detected rise; every pulse shows period=5, high_cnt=3, period_ok=1, duty_ok=1, err_cnt=0.
- Period-6 pattern (high 3, low 3): period=6, period_ok=0, duty_ok=1; err_cnt increments by 1 per measurement; 300 periods saturate err_cnt at 255.
- Duty fault (high 4, low 1): period=5, period_ok=1, high_cnt=4, duty_ok=0, err_cnt increments.
- Stuck clock: after 3 good periods hold sig_in=0; stuck=1 exactly when per_cnt reaches 32, state IDLE, no meas_valid, period still 5. Resume the pattern: stuck clears at the first meas_valid, two rises later.
- Edge on timeout boundary (low phase stretched so the rise lands in the cycle per_cnt==32): meas_valid with period=32, stuck stays 0.
- Mid-measurement disturbance:
  - Drop en for 1 cycle mid-period: no meas_valid for that period, outputs hold, re-arm on the next rise.
  - Assert rst asynchronously mid-period: all outputs 0 immediately, next valid after two rises.
